wb_queue: RTL and testbench

Write-back queue that initiates writes into the 8×8-bit register file's single write port (we3/wa3/wd3).
- Accepts result writes from the execute/memory side through a valid/ready handshake and buffers them in a small in-order FIFO.
- Retires at most one entry per cycle into the register file.
- Provides two bypass lookups so readers see pending (not yet retired) values, newest entry first.

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_match.sv | 33 +++
 rtl/wb_queue.sv | 116 +++++++++++
 tb/tb_wb_queue.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants and the queue entry type for the write-back queue.
package wb_pkg;

  localparam int WB_DW = 8;
  localparam int WB_AW = 3;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Bypass lookup: finds the newest occupied queue entry whose address matches ra.
module wb_match
  import wb_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  wb_entry_t         entries [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PW-1:0]     tail,
  input  logic [WB_AW-1:0]  ra,
  output logic              hit,
  output logic [WB_DW-1:0]  data
);

  logic [PW-1:0] idx;

  // Walk oldest to newest so the last match assigned is the newest one.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PW'(k);
      if (valid[idx] && (entries[idx].addr == ra)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// In-order write-back queue feeding the register file write port, with two
// bypass lookups over pending entries.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = WB_DW,
  parameter int AW    = WB_AW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  output logic                       in_ready,
  input  logic                       wp_stall,
  output logic                       we3,
  output logic [AW-1:0]              wa3,
  output logic [DW-1:0]              wd3,
  input  logic [AW-1:0]              ra1,
  input  logic [AW-1:0]              ra2,
  output logic                       hit1,
  output logic                       hit2,
  output logic [DW-1:0]              fwd1,
  output logic [DW-1:0]              fwd2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry widths come from wb_entry_t; DW/AW are expected to stay at the defaults.
  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_mask;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q != CW'(DEPTH));
  assign we3      = !empty && !wp_stall;
  assign wa3      = empty ? '0 : mem_q[head_q].addr;
  assign wd3      = empty ? '0 : mem_q[head_q].data;
  assign count    = count_q;

  assign push = in_valid && in_ready;
  assign pop  = we3;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (push) begin
      mem_d[tail_q] = '{addr: in_addr, data: in_data};
      tail_d        = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Entry i is occupied when its distance from head is below count.
  always_comb begin
    valid_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_mask[i] = ({1'b0, PW'(i) - head_q} < count_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage is not reset; occupancy is governed solely by head/count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  wb_match #(.DEPTH(DEPTH)) u_match1 (
    .entries (mem_q),
    .valid   (valid_mask),
    .tail    (tail_q),
    .ra      (ra1),
    .hit     (hit1),
    .data    (fwd1)
  );

  wb_match #(.DEPTH(DEPTH)) u_match2 (
    .entries (mem_q),
    .valid   (valid_mask),
    .tail    (tail_q),
    .ra      (ra2),
    .hit     (hit2),
    .data    (fwd2)
  );

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: reset, latency, stall/full, bypass, wrap, async reset.
module tb_wb_queue;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_addr;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wp_stall;
  logic       we3;
  logic [2:0] wa3;
  logic [7:0] wd3;
  logic [2:0] ra1, ra2;
  logic       hit1, hit2;
  logic [7:0] fwd1, fwd2;
  logic [2:0] count;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
    int         cyc;
  } wr_t;

  wr_t        log_q[$];
  logic [7:0] rf [8];
  int         cyc;
  int         total;
  int         bad;

  wb_queue dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wp_stall (wp_stall),
    .we3      (we3),
    .wa3      (wa3),
    .wd3      (wd3),
    .ra1      (ra1),
    .ra2      (ra2),
    .hit1     (hit1),
    .hit2     (hit2),
    .fwd1     (fwd1),
    .fwd2     (fwd2),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: captures every write-port transaction at the edge.
  always @(posedge clk) begin
    if (we3) begin
      log_q.push_back('{a: wa3, d: wd3, cyc: cyc});
      rf[wa3] <= wd3;
    end
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] a, input logic [7:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20; k++) begin
      if (count == 3'd0) break;
      tick();
    end
    check(tag, count, 0);
  endtask

  task automatic check_log(input string tag, input int idx, input logic [2:0] a, input logic [7:0] d);
    if (log_q.size() > idx) begin
      check({tag, "_addr"}, log_q[idx].a, a);
      check({tag, "_data"}, log_q[idx].d, d);
    end else begin
      check({tag, "_missing"}, log_q.size(), idx + 1);
    end
  endtask

  initial begin
    int base;
    int sent;
    int max_cnt;
    bit accepted;

    total    = 0;
    bad      = 0;
    cyc      = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    wp_stall = 1'b0;
    ra1      = '0;
    ra2      = '0;
    for (int i = 0; i < 8; i++) rf[i] = '0;

    // Reset state
    #2;
    check("rst_count", count, 0);
    check("rst_we3", we3, 0);
    check("rst_wa3", wa3, 0);
    check("rst_wd3", wd3, 0);
    check("rst_hit1", hit1, 0);
    check("rst_fwd2", fwd2, 0);
    check("rst_ready", in_ready, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("idle_count", count, 0);
    check("idle_we3", we3, 0);
    check("idle_ready", in_ready, 1);

    // Single write, one-cycle latency
    push(3'd5, 8'hA3);
    ra1 = 3'd5;
    #1;
    check("single_count", count, 1);
    check("single_we3", we3, 1);
    check("single_wa3", wa3, 5);
    check("single_wd3", wd3, 8'hA3);
    check("single_hit1_head", hit1, 1);
    check("single_fwd1_head", fwd1, 8'hA3);
    tick();
    check("single_count_after", count, 0);
    check("single_we3_after", we3, 0);
    check("single_wa3_empty", wa3, 0);
    check("single_hit1_after", hit1, 0);
    check("single_log_size", log_q.size(), 1);
    check_log("single_log", 0, 3'd5, 8'hA3);

    // Stall, fill, held fifth write, full-queue release
    base     = log_q.size();
    wp_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(3'(i), 8'h10 + 8'(i));
    check("full_count", count, 4);
    check("full_ready", in_ready, 0);
    check("full_we3", we3, 0);
    in_valid = 1'b1;
    in_addr  = 3'd7;
    in_data  = 8'h55;
    tick();
    check("held_count", count, 4);
    wp_stall = 1'b0;
    #1;
    check("release_we3", we3, 1);
    check("release_ready", in_ready, 0);
    check("release_wd3", wd3, 8'h10);
    tick();
    check("release_count", count, 3);
    check("release_ready_next", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("accept_count", count, 3);
    drain("full_drain");
    check("full_log_size", log_q.size() - base, 5);
    for (int i = 0; i < 4; i++) check_log("full_order", base + i, 3'(i), 8'h10 + 8'(i));
    check_log("full_held", base + 4, 3'd7, 8'h55);
    if (log_q.size() >= base + 4) begin
      for (int i = 0; i < 3; i++)
        check("full_consec", log_q[base + i + 1].cyc - log_q[base + i].cyc, 1);
    end

    // Bypass with duplicate addresses
    base     = log_q.size();
    wp_stall = 1'b1;
    push(3'd2, 8'h11);
    push(3'd2, 8'h22);
    ra1 = 3'd2;
    ra2 = 3'd3;
    #1;
    check("byp_hit1", hit1, 1);
    check("byp_fwd1", fwd1, 8'h22);
    check("byp_hit2", hit2, 0);
    check("byp_fwd2", fwd2, 0);
    push(3'd3, 8'h33);
    check("byp_hit2_new", hit2, 1);
    check("byp_fwd2_new", fwd2, 8'h33);
    check("byp_fwd1_keep", fwd1, 8'h22);
    in_valid = 1'b1;
    in_addr  = 3'd4;
    in_data  = 8'h44;
    ra2      = 3'd4;
    #1;
    check("byp_incoming_hit", hit2, 0);
    check("byp_incoming_fwd", fwd2, 0);
    tick();
    in_valid = 1'b0;
    check("byp_stored_hit", hit2, 1);
    check("byp_stored_fwd", fwd2, 8'h44);
    check("byp_count", count, 4);
    wp_stall = 1'b0;
    drain("byp_drain");
    tick();
    check("byp_rf2_lastwins", rf[2], 8'h22);
    check("byp_rf3", rf[3], 8'h33);
    check_log("byp_log0", base, 3'd2, 8'h11);
    check_log("byp_log1", base + 1, 3'd2, 8'h22);
    check_log("byp_log3", base + 3, 3'd4, 8'h44);

    // Pointer wrap under toggling stall
    base    = log_q.size();
    sent    = 0;
    max_cnt = 0;
    for (int t = 0; t < 100; t++) begin
      if (sent == 10 && count == 3'd0) break;
      wp_stall = ((t / 3) % 2) == 1;
      in_valid = (sent < 10);
      in_addr  = 3'(sent);
      in_data  = 8'(sent + 1);
      #1;
      accepted = in_valid && in_ready;
      tick();
      if (accepted) sent++;
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    in_valid = 1'b0;
    wp_stall = 1'b0;
    check("wrap_sent", sent, 10);
    check("wrap_empty", count, 0);
    check("wrap_max_le4", (max_cnt <= 4), 1);
    check("wrap_log_size", log_q.size() - base, 10);
    for (int i = 0; i < 10; i++) check_log("wrap_order", base + i, 3'(i), 8'(i + 1));

    // Async reset with pending entries
    wp_stall = 1'b1;
    push(3'd1, 8'hC1);
    push(3'd2, 8'hC2);
    push(3'd3, 8'hC3);
    check("arst_pre_count", count, 3);
    wp_stall = 1'b0;
    #1;
    check("arst_pre_we3", we3, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_we3", we3, 0);
    check("arst_ready", in_ready, 1);
    base = log_q.size();
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    tick();
    check("arst_no_writes", log_q.size(), base);
    check("arst_count_after", count, 0);
    check("arst_hit_after", hit1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
